// File: rtl/alu_selftest.sv
// alu_selftest: on-chip self-test sequencer for the 32-bit ALU.
// It owns the ALU input side. Vectors (command, operands, expected result,
// expected flags, flag mask) are written into a small store. A start pulse
// then runs the first n vectors in order and tallies passes and failures.
// It also records the index of the first failing vector.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   vec_we, vec_addr, vec_*    vector store write port (dropped while busy)
//   vec_count                  number of vectors to run, sampled at start
//   start                      run request pulse (ignored while busy)
//   alu_command/operandA/B     registered drive to the ALU
//   alu_result, alu_carryout,
//   alu_zero, alu_overflow     ALU outputs under test
//   busy, done                 run in progress / end-of-run pulse
//   pass_count, fail_count     per-run tallies
//   first_fail_valid/idx       first failing vector of the run
//
// state     | meaning
// ST_IDLE   | waiting for start; results of the last run held
// ST_APPLY  | drive entry[idx] onto the ALU, load settle timer
// ST_SETTLE | wait SETTLE cycles for the ALU outputs
// ST_CHECK  | compare result/flags, update tallies, advance idx
// ST_DONE   | one-cycle done pulse
module alu_selftest #(
    parameter int NUM_VECTORS = 8,
    parameter int SETTLE      = 2,
    localparam int IW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
    localparam int CW = $clog2(NUM_VECTORS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vec_we,
    input  logic [IW-1:0] vec_addr,
    input  logic [2:0]    vec_cmd,
    input  logic [31:0]   vec_a,
    input  logic [31:0]   vec_b,
    input  logic [31:0]   vec_exp_result,
    input  logic [2:0]    vec_exp_flags,
    input  logic [2:0]    vec_flag_mask,
    input  logic [CW-1:0] vec_count,
    input  logic          start,
    output logic [2:0]    alu_command,
    output logic [31:0]   alu_operandA,
    output logic [31:0]   alu_operandB,
    input  logic [31:0]   alu_result,
    input  logic          alu_carryout,
    input  logic          alu_zero,
    input  logic          alu_overflow,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pass_count,
    output logic [CW-1:0] fail_count,
    output logic          first_fail_valid,
    output logic [IW-1:0] first_fail_idx
);

    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t        state, state_nxt;
    logic          load_run;
    logic          last_vec;
    logic          match;
    logic [2:0]    flags_now;
    logic [CW-1:0] run_n;
    logic [CW-1:0] run_n_in;
    logic [IW-1:0] idx;
    logic [SW-1:0] settle_cnt;

    // Vector store: plain registers, deliberately not reset so loaded
    // vectors survive a reset of the sequencer.
    logic [2:0]  mem_cmd   [NUM_VECTORS];
    logic [31:0] mem_a     [NUM_VECTORS];
    logic [31:0] mem_b     [NUM_VECTORS];
    logic [31:0] mem_exp   [NUM_VECTORS];
    logic [2:0]  mem_flags [NUM_VECTORS];
    logic [2:0]  mem_mask  [NUM_VECTORS];

    always_ff @(posedge clk) begin
        if (vec_we && !busy && (int'(vec_addr) < NUM_VECTORS)) begin
            mem_cmd[vec_addr]   <= vec_cmd;
            mem_a[vec_addr]     <= vec_a;
            mem_b[vec_addr]     <= vec_b;
            mem_exp[vec_addr]   <= vec_exp_result;
            mem_flags[vec_addr] <= vec_exp_flags;
            mem_mask[vec_addr]  <= vec_flag_mask;
        end
    end

    assign run_n_in  = (vec_count > CW'(NUM_VECTORS)) ? CW'(NUM_VECTORS) : vec_count;
    assign last_vec  = (CW'(idx) == run_n - CW'(1));
    assign flags_now = {alu_carryout, alu_zero, alu_overflow};
    // Masked-off flags never cause a mismatch.
    assign match     = (alu_result == mem_exp[idx]) &&
                       (((flags_now ^ mem_flags[idx]) & mem_mask[idx]) == 3'b000);

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_run  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load_run  = 1'b1;
                    state_nxt = (run_n_in == '0) ? ST_DONE : ST_APPLY;
                end
            end
            ST_APPLY:  state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_cnt == SW'(1)) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK:  state_nxt = last_vec ? ST_DONE : ST_APPLY;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_command      <= 3'b000;
            alu_operandA     <= '0;
            alu_operandB     <= '0;
            pass_count       <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            idx              <= '0;
            run_n            <= '0;
            settle_cnt       <= '0;
        end else begin
            if (load_run) begin
                pass_count       <= '0;
                fail_count       <= '0;
                first_fail_valid <= 1'b0;
                first_fail_idx   <= '0;
                idx              <= '0;
                run_n            <= run_n_in;
            end
            if (state == ST_APPLY) begin
                alu_command  <= mem_cmd[idx];
                alu_operandA <= mem_a[idx];
                alu_operandB <= mem_b[idx];
                settle_cnt   <= SW'(SETTLE);
            end
            if (state == ST_SETTLE) begin
                settle_cnt <= settle_cnt - SW'(1);
            end
            if (state == ST_CHECK) begin
                if (match) begin
                    pass_count <= pass_count + CW'(1);
                end else begin
                    fail_count <= fail_count + CW'(1);
                    if (!first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_idx   <= idx;
                    end
                end
                if (!last_vec) begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_selftest.sv
// Bench for alu_selftest: three instances (SETTLE = 2, 1, 5) share the
// vector write bus and reset. Each one drives its own behavioural ALU.
// Run expectations and operand expectations are queued when a start is
// driven and consumed as the DUT reaches the corresponding cycles.
module tb_alu_selftest;

    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [2:0]  flg;
        logic [2:0]  msk;
    } vec_t;

    typedef struct {
        int          cyc;
        int          g;
        logic [2:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef struct {
        int cyc;
        int g;
        int pas;
        int fal;
        int ffv;
        int ffi;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        vec_we;
    logic [2:0]  vec_addr;
    logic [2:0]  vec_cmd;
    logic [31:0] vec_a, vec_b, vec_exp_result;
    logic [2:0]  vec_exp_flags, vec_flag_mask;
    logic [3:0]  vec_count;
    logic [2:0]  start_v;

    logic [2:0]  cmd_v [3];
    logic [31:0] opa_v [3];
    logic [31:0] opb_v [3];
    logic [31:0] res_v [3];
    logic [2:0]  car_v, zer_v, ovf_v, busy_v, done_v, ffv_v;
    logic [3:0]  pass_v [3];
    logic [3:0]  fail_v [3];
    logic [2:0]  ffi_v [3];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   idle_cyc = -1;
    int   idle_g = 0;
    vec_t tbl [14];
    vec_t shadow [8];
    op_t  op_q [$];
    res_t res_q [$];

    // Behavioural ALU: returns {carryout, zero, overflow, result}.
    function automatic logic [34:0] alu_f(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        co, ov;
        s = '0; r = '0; co = 1'b0; ov = 1'b0;
        case (c)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; co = s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a ^ b;
            3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: r = a & b;
            3'd5: r = ~(a & b);
            3'd6: r = ~(a | b);
            default: r = a | b;
        endcase
        return {co, (r == 32'd0), ov, r};
    endfunction

    function automatic int settle_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        alu_selftest #(.NUM_VECTORS(8), .SETTLE((g == 0) ? 2 : ((g == 1) ? 1 : 5))) u_dut (
            .clk              (clk),
            .reset            (reset),
            .vec_we           (vec_we),
            .vec_addr         (vec_addr),
            .vec_cmd          (vec_cmd),
            .vec_a            (vec_a),
            .vec_b            (vec_b),
            .vec_exp_result   (vec_exp_result),
            .vec_exp_flags    (vec_exp_flags),
            .vec_flag_mask    (vec_flag_mask),
            .vec_count        (vec_count),
            .start            (start_v[g]),
            .alu_command      (cmd_v[g]),
            .alu_operandA     (opa_v[g]),
            .alu_operandB     (opb_v[g]),
            .alu_result       (res_v[g]),
            .alu_carryout     (car_v[g]),
            .alu_zero         (zer_v[g]),
            .alu_overflow     (ovf_v[g]),
            .busy             (busy_v[g]),
            .done             (done_v[g]),
            .pass_count       (pass_v[g]),
            .fail_count       (fail_v[g]),
            .first_fail_valid (ffv_v[g]),
            .first_fail_idx   (ffi_v[g])
        );
        assign {car_v[g], zer_v[g], ovf_v[g], res_v[g]} = alu_f(cmd_v[g], opa_v[g], opb_v[g]);
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic drive(input int addr, input vec_t v);
        vec_addr       = 3'(addr);
        vec_cmd        = v.cmd;
        vec_a          = v.a;
        vec_b          = v.b;
        vec_exp_result = v.exp;
        vec_exp_flags  = v.flg;
        vec_flag_mask  = v.msk;
    endtask

    task automatic wr(input int addr, input vec_t v);
        drive(addr, v);
        vec_we = 1'b1;
        @(negedge clk);
        vec_we = 1'b0;
        shadow[addr] = v;
    endtask

    // Called once per negedge: consumes due expectations.
    task automatic mon_step();
        op_t  o;
        res_t r;
        while (op_q.size() > 0 && op_q[0].cyc <= cyc) begin
            o = op_q.pop_front();
            chk($sformatf("op_cmd%0d@%0d", o.g, o.cyc), 32'(cmd_v[o.g]), 32'(o.cmd));
            chk($sformatf("op_a%0d@%0d", o.g, o.cyc), opa_v[o.g], o.a);
            chk($sformatf("op_b%0d@%0d", o.g, o.cyc), opb_v[o.g], o.b);
        end
        if (idle_cyc == cyc) begin
            chk("busy_after_done", 32'(busy_v[idle_g]), 0);
            idle_cyc = -1;
        end
        for (int g = 0; g < 3; g++) begin
            if (done_v[g]) begin
                if (res_q.size() == 0 || res_q[0].g != g) begin
                    chk($sformatf("unexpected_done%0d", g), 32'(done_v[g]), 0);
                end else begin
                    r = res_q.pop_front();
                    chk("done_cycle", cyc, r.cyc);
                    chk("pass_count", 32'(pass_v[g]), r.pas);
                    chk("fail_count", 32'(fail_v[g]), r.fal);
                    chk("first_fail_valid", 32'(ffv_v[g]), r.ffv);
                    chk("first_fail_idx", 32'(ffi_v[g]), r.ffi);
                    chk("busy_at_done", 32'(busy_v[g]), 1);
                    idle_cyc = cyc + 1;
                    idle_g   = g;
                end
            end
        end
    endtask

    // mode: 0 plain, 1 start again mid-run, 2 write entry 0 mid-run,
    // 3 write entry 0 in the same cycle as start.
    task automatic run(input int g, input int cnt, input int mode, input vec_t alt);
        int   n, S, s, pas, fal, ffv, ffi, base, budget;
        logic [34:0] m;
        n = (cnt > 8) ? 8 : cnt;
        S = settle_of(g);
        if (mode == 3) begin
            drive(0, alt);
            vec_we = 1'b1;
            shadow[0] = alt;
        end
        s = cyc; pas = 0; fal = 0; ffv = 0; ffi = 0;
        for (int k = 0; k < n; k++) begin
            m = alu_f(shadow[k].cmd, shadow[k].a, shadow[k].b);
            if (m[31:0] == shadow[k].exp && ((m[34:32] ^ shadow[k].flg) & shadow[k].msk) == 3'b000)
                pas++;
            else begin
                fal++;
                if (ffv == 0) begin ffv = 1; ffi = k; end
            end
            base = s + 2 + k * (S + 2);
            op_q.push_back('{base, g, shadow[k].cmd, shadow[k].a, shadow[k].b});
            op_q.push_back('{base + S, g, shadow[k].cmd, shadow[k].a, shadow[k].b});
        end
        if (n > 0)
            op_q.push_back('{s + 3 + n * (S + 2), g, shadow[n-1].cmd, shadow[n-1].a, shadow[n-1].b});
        res_q.push_back('{s + 1 + n * (S + 2), g, pas, fal, ffv, ffi});
        vec_count  = 4'(cnt);
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
        vec_we     = 1'b0;
        vec_count  = 4'd0;
        mon_step();
        chk("busy_after_start", 32'(busy_v[g]), 1);
        budget = 0;
        while ((op_q.size() > 0 || res_q.size() > 0 || idle_cyc >= 0) && budget < 300) begin
            if (cyc == s + 5 && mode == 1) start_v[g] = 1'b1;
            if (cyc == s + 5 && mode == 2) begin
                drive(0, alt);
                vec_we = 1'b1;
            end
            @(negedge clk);
            start_v[g] = 1'b0;
            vec_we     = 1'b0;
            budget++;
            mon_step();
        end
        if (budget >= 300) begin
            chk("run_timeout", budget, 0);
            op_q.delete();
            res_q.delete();
            idle_cyc = -1;
        end
    endtask

    initial begin
        int s;
        tbl[0]  = '{3'd0, 32'h00000000, 32'h00000000, 32'h00000000, 3'b010, 3'b111};
        tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 3'b110, 3'b111};
        tbl[2]  = '{3'd1, 32'hAAAAAAAA, 32'h55555555, 32'h55555555, 3'b101, 3'b111};
        tbl[3]  = '{3'd2, 32'hAAAAAAAA, 32'h33333333, 32'h99999999, 3'b000, 3'b000};
        tbl[4]  = '{3'd3, 32'h80000000, 32'h00000001, 32'h00000001, 3'b000, 3'b111};
        tbl[5]  = '{3'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 3'b000, 3'b010};
        tbl[6]  = '{3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 3'b010, 3'b010};
        tbl[7]  = '{3'd6, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 3'b000, 3'b010};
        tbl[8]  = '{3'd1, 32'hAAAAAAAA, 32'h55555555, 32'h55555555, 3'b100, 3'b111};
        tbl[9]  = '{3'd2, 32'hAAAAAAAA, 32'h33333333, 32'h99999998, 3'b000, 3'b000};
        tbl[10] = '{3'd2, 32'hAAAAAAAA, 32'h33333333, 32'h99999999, 3'b111, 3'b000};
        tbl[11] = '{3'd2, 32'hAAAAAAAA, 32'h33333333, 32'h99999999, 3'b010, 3'b010};
        tbl[12] = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 3'b010, 3'b011};
        tbl[13] = '{3'd7, 32'h12345678, 32'h0F0F0000, 32'h1F3F5678, 3'b000, 3'b111};

        reset = 1'b1; vec_we = 1'b0; start_v = 3'b000; vec_count = 4'd0;
        drive(0, tbl[0]);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_busy%0d", g), 32'(busy_v[g]), 0);
            chk($sformatf("rst_done%0d", g), 32'(done_v[g]), 0);
            chk($sformatf("rst_pass%0d", g), 32'(pass_v[g]), 0);
            chk($sformatf("rst_cmd%0d", g), 32'(cmd_v[g]), 0);
            chk($sformatf("rst_a%0d", g), opa_v[g], 0);
        end
        reset = 1'b0;
        @(negedge clk);

        // pass run, fail detection, flag masking
        for (int k = 0; k < 4; k++) wr(k, tbl[k]);
        run(0, 4, 0, tbl[13]);
        wr(2, tbl[8]);
        wr(3, tbl[9]);
        run(0, 4, 0, tbl[13]);
        for (int k = 0; k < 3; k++) wr(k, tbl[10 + k]);
        run(0, 3, 0, tbl[13]);

        // count boundaries
        run(0, 0, 0, tbl[13]);
        for (int k = 0; k < 8; k++) wr(k, tbl[k]);
        run(0, 15, 0, tbl[13]);

        // start/write while busy, write together with start
        run(0, 4, 1, tbl[13]);
        run(0, 4, 2, tbl[13]);
        run(0, 4, 0, tbl[13]);
        run(0, 1, 3, tbl[13]);

        // reset during SETTLE of vector 2
        for (int k = 0; k < 4; k++) wr(k, tbl[k]);
        s = cyc;
        vec_count = 4'd4; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        while (cyc < s + 10) @(negedge clk);
        chk("pass_before_reset", 32'(pass_v[0]), 2);
        chk("cmd_before_reset", 32'(cmd_v[0]), 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy_v[0]), 0);
        chk("rst_mid_done", 32'(done_v[0]), 0);
        chk("rst_mid_pass", 32'(pass_v[0]), 0);
        chk("rst_mid_cmd", 32'(cmd_v[0]), 0);
        chk("rst_mid_a", opa_v[0], 0);
        chk("rst_mid_b", opb_v[0], 0);
        repeat (2) begin
            @(negedge clk);
            chk("done_in_reset", 32'(done_v[0]), 0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("done_after_reset", 32'(done_v[0]), 0);
        run(0, 4, 0, tbl[13]);

        // SETTLE = 1 and SETTLE = 5 timing
        for (int k = 0; k < 3; k++) wr(k, tbl[k]);
        run(1, 3, 0, tbl[13]);
        run(2, 3, 0, tbl[13]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_selftest.md
# alu_selftest

Synthesizable self-test sequencer that drives the 32-bit ALU's command/operand inputs and checks its result and flag outputs against stored expected values. It replaces the simulation-only directed bench with an on-chip engine: vectors are loaded through a write port, a start pulse runs them in order, and pass/fail counts plus the first failing index are reported. It sits beside the ALU instance and owns the ALU's input side.

## Interface
- NUM_VECTORS, 8: vector store depth (≥1); IW = max(1, $clog2(NUM_VECTORS)), CW = $clog2(NUM_VECTORS+1)
- SETTLE, 2: cycles the ALU outputs are allowed to settle before sampling (≥1)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- vec_we  in  1  write vector store entry (ignored while busy)
- vec_addr  in  IW  entry index
- vec_cmd  in  3  ALU command (000 add, 001 sub, 010 xor, 011 slt, 100 and, 101 nand, 110 nor, 111 or)
- vec_a, vec_b  in  32  operands
- vec_exp_result  in  32  expected result
- vec_exp_flags  in  3  expected {carryout, zero, overflow}
- vec_flag_mask  in  3  1 = compare that flag, same bit order
- vec_count  in  CW  number of vectors to run, sampled at start
- start  in  1  run request, single-cycle pulse
- alu_command  out  3  to ALU command
- alu_operandA, alu_operandB  out  32  to ALU operands
- alu_result  in  32  from ALU
- alu_carryout, alu_zero, alu_overflow  in  1  from ALU
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pass_count, fail_count  out  CW  per-run tallies
- first_fail_valid  out  1  at least one failure this run
- first_fail_idx  out  IW  index of first failing vector

## Operation
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE: busy=0. start=1 → clear pass_count, fail_count, first_fail_valid, first_fail_idx; idx←0; latch n = min(vec_count, NUM_VECTORS); n=0 → DONE, else → APPLY.
- APPLY: alu_command/operandA/operandB ← entry[idx]; load settle counter with SETTLE; → SETTLE.
- SETTLE: decrement counter; remain exactly SETTLE cycles, then → CHECK.
- CHECK: match = (alu_result == exp_result) and, for each mask bit set, flag == expected flag. Match → pass_count+1; else fail_count+1, and if first_fail_valid=0 set it to 1 with first_fail_idx←idx. Then if idx == n−1 → DONE, else idx+1 → APPLY.
- DONE: done=1 for this cycle only; → IDLE.
- busy=1 in APPLY, SETTLE, CHECK, DONE.
- Vector store: one registered write per cycle when vec_we=1 and busy=0; writes while busy are dropped. Store is not reset; its contents persist across runs and resets.
- ALU drive registers hold their last applied vector after the run ends; they change only in APPLY or on reset.
- start while busy is ignored. start in the same cycle as a vec_we in IDLE: the write completes and the run starts; entry 0 read in APPLY sees the new data.
- pass_count + fail_count = n at DONE; counts, first_fail_* hold until the next start.

## Timing
- Reset values (asynchronous): state IDLE, alu_command=000, alu_operandA=0, alu_operandB=0, busy=0, done=0, pass_count=0, fail_count=0, first_fail_valid=0, first_fail_idx=0, idx=0.
- Reset mid-run aborts immediately to IDLE with the values above; no done pulse.
- start sampled at edge T → busy=1 from T+1; first APPLY at T+1.
- Per vector: 1 (APPLY) + SETTLE + 1 (CHECK) cycles; ALU outputs sampled at the end of the CHECK cycle, SETTLE+1 cycles after operands change.
- Run of n vectors: done asserted in cycle T+1+n·(SETTLE+2); busy falls the cycle after done. n=0: done at T+1.
- Counters update at the end of CHECK and are visible the next cycle.

## Test plan
- Reset: assert reset mid-run (during SETTLE of vector 2) → all outputs to reset values asynchronously, no done; new start runs from idx 0.
- Pass run: load 4 vectors against a behavioral ALU: add 0+0 → 0 {c0,z1,o0} mask 111; sub FFFFFFFF−FFFFFFFF → 0 {c1,z1,o0}; sub AAAAAAAA−55555555 → 55555555 {c1,z0,o1}; xor AAAAAAAA^33333333 → 99999999 mask 000; vec_count=4, SETTLE=2 → done at start+17, pass=4, fail=0, first_fail_valid=0.
- Fail detection: same set, vector 2 expected overflow=0 and vector 3 expected 99999998 → pass=2, fail=2, first_fail_idx=2.
- Flag masking: xor vector with wrong expected flags and mask 000 → pass; same with mask 010 and wrong zero → fail.
- Boundaries: vec_count=0 → done one cycle after start, counts 0; vec_count=15 with NUM_VECTORS=8 → 8 vectors run; start during busy ignored; vec_we during busy leaves entry unchanged (verified by rerun).
- Timing: SETTLE=1 and SETTLE=5 runs of 3 vectors → done at start+1+3·(SETTLE+2); ALU operands stable from APPLY through CHECK.
